truth_table_sweeper: RTL and testbench
======================================

// Module: truth_table_sweeper
// PURPOSE
//  Upstream stimulus stage for the 2-input demo combinational blocks: steps an N-bit input vector
//  (count) through every value 0..2^N-1 and holds each value for HOLD_CYCLES clocks.
//  Samples the downstream block's output f at the end of each hold window and packs the samples
//  into a truth-table word. Replaces hand-written #delay stimulus with a synthesizable, self-timed sweep.
// PARAMETERS
//  N_IN         2   width of count; sweep length = 2**N_IN vectors (1..8 supported)
//  HOLD_CYCLES  20  clocks each vector is held before f is sampled (>=1)
// PORTS
//  clk     in   1         single clock, rising edge
//  rst_n   in   1         asynchronous, active-low reset
//  start   in   1         begin a sweep; sampled only in IDLE
//  abort   in   1         synchronous cancel of a running sweep
//  f       in   1         output of the block under stimulus
//  count   out  N_IN      input vector driven to the block under stimulus
//  busy    out  1         high while a sweep is in progress
//  done    out  1         one-cycle pulse when a sweep completes
//  result  out  2**N_IN   result[i] = f sampled while count==i
//  valid   out  1         result holds a complete sweep
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; count, busy, done, result, valid, hold counter = 0.
//  - FSM states: IDLE, DRIVE, DONE.
//  - IDLE: busy=0, count=0. On start=1 and abort=0: go to DRIVE. Clear result and valid.
//    Set count=0 and hold=0.
//  - DRIVE: busy=1, count held stable. hold increments every clock.
//    On the edge where hold==HOLD_CYCLES-1: result[count]<=f and hold<=0.
//    If count==2**N_IN-1, go to DONE. Otherwise count<=count+1 (no wrap inside a sweep).
//  - DONE (one cycle): done=1, busy=0. valid<=1. Next edge: IDLE, count<=0.
//  - Latency: done is high in the cycle after edge 2**N_IN*HOLD_CYCLES, counted from the edge
//    that sampled start. Defaults give edge 80.
//  - f is sampled only on the last cycle of each hold window. This gives the downstream block
//    HOLD_CYCLES-1 clocks to settle.
//  - start while busy or in DONE is ignored. A held-high start gives exactly one sweep per
//    IDLE visit. A new sweep may begin the cycle after DONE.
//  - abort=1 in DRIVE: next edge goes to IDLE. count=0, hold=0, valid=0, no done pulse.
//    Partial result bits are undefined-but-stable.
//  - start and abort both high in IDLE: abort wins and the block stays IDLE.
//  - abort in DONE: ignored; the sweep is already complete.
//  - rst_n asserted mid-sweep: immediate return to reset values. No done when rst_n releases.
//  - hold counter width = clog2(HOLD_CYCLES) with a minimum of 1. For HOLD_CYCLES=1 every
//    DRIVE cycle samples.
// STRUCTURE
//  - sweep_pkg: state encoding localparams (IDLE/DRIVE/DONE), clog2 function,
//    default N_IN/HOLD_CYCLES.
//  - Sub-module hold_timer (HOLD_CYCLES param): clear and enable inputs, terminal-count
//    output tc. Instantiated once.
//  - Top: FSM, count register and result shift/index write. All outputs registered.
// TESTING
//  1. rst_n=0 for 3 clocks with start=1 -> count=0, busy=0, done=0, result=0, valid=0 throughout.
//  2. f=count[1]&count[0], 1-cycle start pulse -> count 0,1,2,3 each held 20 clocks;
//     done at edge 80; result=4'b1000; valid=1.
//  3. f=count[1]^count[0], start -> result=4'b0110. Rerun with f=~count[0] -> result=4'b0101;
//     valid drops at the restart.
//  4. abort at edge 30 (count=1) -> IDLE next edge, count=0, valid=0, no done.
//     A following start completes a normal sweep at +80.
//  5. HOLD_CYCLES=1, start held high for 10 clocks -> done at edge 4, then a second sweep starts
//     after DONE. Check exactly one done per sweep.
//  6. rst_n low at edge 45 (count=2) -> all outputs 0 asynchronously. After release with start=0,
//     the block stays IDLE and no done appears.

Source files
------------

// File: rtl/sweep_pkg.sv
// Shared definitions for the truth-table sweeper: FSM encoding, defaults, clog2 helper.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
package sweep_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Default sweep shape: 2-input blocks, 20 clocks of settle per vector
  localparam int DEF_N_IN        = 2;
  localparam int DEF_HOLD_CYCLES = 20;

  // Ceiling log2; returns 0 for values of 0 or 1
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Hold-window timer: counts enabled clocks and flags the last clock of each window.
// Latency: tc is combinational from the registered count, high on clock HOLD_CYCLES of a window.
// Backpressure: none; clear has priority and parks the counter at zero while disabled.
module hold_timer import sweep_pkg::*; #(
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tc
);

  // At least one bit so HOLD_CYCLES=1 still has a legal (always-zero) counter
  localparam int HW = (clog2(HOLD_CYCLES) < 1) ? 1 : clog2(HOLD_CYCLES);
  localparam logic [HW-1:0] LAST = HW'(HOLD_CYCLES - 1);

  logic [HW-1:0] hold;

  assign tc = en && (hold == LAST);

  // Count enabled clocks, restarting after the terminal count or on clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
    end else if (clear || tc) begin
      hold <= '0;
    end else if (en) begin
      hold <= hold + HW'(1);
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Steps count through every N_IN-bit vector, holds each HOLD_CYCLES clocks and packs sampled f into result.
// Latency: done is high in the cycle after edge 2**N_IN*HOLD_CYCLES counted from the edge that took start.
// Backpressure: none; start is only honoured in IDLE, abort cancels a running sweep on the next edge.
module truth_table_sweeper import sweep_pkg::*; #(
  parameter int N_IN        = DEF_N_IN,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 f,
  output logic [N_IN-1:0]      count,
  output logic                 busy,
  output logic                 done,
  output logic [(2**N_IN)-1:0] result,
  output logic                 valid
);

  localparam logic [N_IN-1:0] LAST_VEC = '1;

  logic [1:0] state;
  logic       tmr_en;
  logic       tmr_tc;

  // The timer only runs while a sweep is live; an abort cycle also clears it
  assign tmr_en = (state == ST_DRIVE) && !abort;

  hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_hold (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (!tmr_en),
    .en    (tmr_en),
    .tc    (tmr_tc)
  );

  // Sweep FSM with registered count, status and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      count  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      valid  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          count <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
          // abort beats a simultaneous start
          if (start && !abort) begin
            state  <= ST_DRIVE;
            busy   <= 1'b1;
            result <= '0;
            valid  <= 1'b0;
          end
        end
        ST_DRIVE: begin
          if (abort) begin
            // partial result bits are left as they are
            state <= ST_IDLE;
            count <= '0;
            busy  <= 1'b0;
            valid <= 1'b0;
          end else if (tmr_tc) begin
            result[count] <= f;
            if (count == LAST_VEC) begin
              // count stays on the last vector through DONE
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              valid <= 1'b1;
            end else begin
              count <= count + N_IN'(1);
            end
          end
        end
        ST_DONE: begin
          // single-cycle pulse; start and abort are ignored here
          state <= ST_IDLE;
          done  <= 1'b0;
          count <= '0;
        end
        default: begin
          state <= ST_IDLE;
          count <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: default instance (N_IN=2, HOLD=20) and a HOLD_CYCLES=1 instance.
// Expected result words come from a software model of f and are queued at start, popped at done.
// All checks sample 1 time unit after the rising edge.
module tb_truth_table_sweeper;

  localparam int HOLD  = 20;
  localparam int NVEC  = 4;
  localparam int TOTAL = HOLD * NVEC;

  logic       clk;
  logic       rst_n;

  logic       start1, abort1, f1;
  logic [1:0] count1;
  logic       busy1, done1, valid1;
  logic [3:0] result1;

  logic       start2, abort2, f2;
  logic [1:0] count2;
  logic       busy2, done2, valid2;
  logic [3:0] result2;

  int mode1;
  int mode2;
  int n_cmp;
  int n_err;
  int done_seen1;
  int done_seen2;

  logic [3:0] q1[$];
  logic [3:0] q2[$];

  truth_table_sweeper #(.N_IN(2), .HOLD_CYCLES(HOLD)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .f(f1),
    .count(count1), .busy(busy1), .done(done1), .result(result1), .valid(valid1)
  );

  truth_table_sweeper #(.N_IN(2), .HOLD_CYCLES(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .f(f2),
    .count(count2), .busy(busy2), .done(done2), .result(result2), .valid(valid2)
  );

  // Reference behaviour of the block under stimulus
  function automatic logic fmodel(input int m, input int i);
    logic a, b;
    a = logic'((i >> 1) & 1);
    b = logic'(i & 1);
    case (m)
      0:       return a & b;
      1:       return a ^ b;
      default: return ~b;
    endcase
  endfunction

  function automatic logic [3:0] model_word(input int m);
    logic [3:0] w;
    for (int i = 0; i < NVEC; i++) w[i] = fmodel(m, i);
    return w;
  endfunction

  always_comb f1 = fmodel(mode1, int'(count1));
  always_comb f2 = fmodel(mode2, int'(count2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done1 === 1'b1) done_seen1++;
    if (done2 === 1'b1) done_seen2++;
  end

  task automatic test_reset();
    rst_n = 1'b0;
    start1 = 1'b1; abort1 = 1'b0;
    start2 = 1'b1; abort2 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({count1, busy1, done1, result1, valid1} !== 9'b0) begin
        n_err++;
        $display("FAIL reset_dut1 cyc%0d: got %b want 0", c, {count1, busy1, done1, result1, valid1});
      end
      n_cmp++;
      if ({count2, busy2, done2, result2, valid2} !== 9'b0) begin
        n_err++;
        $display("FAIL reset_dut2 cyc%0d: got %b want 0", c, {count2, busy2, done2, result2, valid2});
      end
    end
    start1 = 1'b0;
    start2 = 1'b0;
    rst_n  = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (busy1 !== 1'b0 || done_seen1 != 0) begin
      n_err++;
      $display("FAIL reset_release: busy=%b dones=%0d want 0/0", busy1, done_seen1);
    end
  endtask

  // One full default-instance sweep with per-edge timing checks
  task automatic do_sweep(input int m, input bit abort_in_done);
    logic [3:0] exp_w;
    logic [1:0] ec;
    mode1 = m;
    q1.push_back(model_word(m));
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    n_cmp++;
    if ({busy1, valid1, count1} !== 4'b1000) begin
      n_err++;
      $display("FAIL sweep_start m%0d: busy,valid,count=%b want 1000", m, {busy1, valid1, count1});
    end
    for (int k = 1; k <= TOTAL; k++) begin
      @(posedge clk); #1;
      if (k < TOTAL) begin
        ec = 2'(k / HOLD);
        n_cmp++;
        if ({count1, busy1, done1} !== {ec, 2'b10}) begin
          n_err++;
          $display("FAIL sweep_edge%0d m%0d: count,busy,done=%b want %b", k, m, {count1, busy1, done1}, {ec, 2'b10});
        end
      end else begin
        n_cmp++;
        if ({count1, busy1, done1, valid1} !== 5'b11011) begin
          n_err++;
          $display("FAIL sweep_done m%0d: count,busy,done,valid=%b want 11011", m, {count1, busy1, done1, valid1});
        end
        n_cmp++;
        if (q1.size() == 0) begin
          n_err++;
          $display("FAIL scoreboard1: queue empty at done, result=%b", result1);
        end else begin
          exp_w = q1.pop_front();
          if (result1 !== exp_w) begin
            n_err++;
            $display("FAIL result m%0d: got %b want %b", m, result1, exp_w);
          end
        end
        if (abort_in_done) abort1 = 1'b1;
      end
    end
    @(posedge clk); #1;
    abort1 = 1'b0;
    n_cmp++;
    if ({count1, busy1, done1, valid1, result1} !== {5'b00001, model_word(m)}) begin
      n_err++;
      $display("FAIL sweep_after m%0d: count,busy,done,valid,result=%b want %b", m,
               {count1, busy1, done1, valid1, result1}, {5'b00001, model_word(m)});
    end
  endtask

  task automatic test_and();
    do_sweep(0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_sweep(1, 1'b0);
    do_sweep(2, 1'b0);
  endtask

  task automatic test_abort();
    int d0;
    mode1 = 0;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int k = 1; k < 30; k++) begin
      @(posedge clk); #1;
    end
    n_cmp++;
    if (count1 !== 2'd1) begin
      n_err++;
      $display("FAIL abort_pre: count=%0d want 1", count1);
    end
    d0 = done_seen1;
    abort1 = 1'b1;
    @(posedge clk); #1;
    abort1 = 1'b0;
    n_cmp++;
    if ({count1, busy1, done1, valid1} !== 5'b0) begin
      n_err++;
      $display("FAIL abort_idle: count,busy,done,valid=%b want 00000", {count1, busy1, done1, valid1});
    end
    repeat (25) begin
      @(posedge clk); #1;
    end
    n_cmp++;
    if (done_seen1 != d0 || busy1 !== 1'b0) begin
      n_err++;
      $display("FAIL abort_nodone: dones=%0d busy=%b want %0d/0", done_seen1, busy1, d0);
    end
    // start and abort together in IDLE: stays idle
    start1 = 1'b1; abort1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; abort1 = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (busy1 !== 1'b0) begin
      n_err++;
      $display("FAIL start_abort_idle: busy=%b want 0", busy1);
    end
    // normal sweep afterwards, with abort raised during DONE
    do_sweep(0, 1'b1);
  endtask

  task automatic test_hold1();
    logic [3:0] exp_w;
    bit want;
    int d0;
    mode2 = 2;
    d0 = done_seen2;
    q2.push_back(model_word(2));
    q2.push_back(model_word(2));
    start2 = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (k == 9) start2 = 1'b0;
      want = (k == 4) || (k == 10);
      n_cmp++;
      if (done2 !== want) begin
        n_err++;
        $display("FAIL hold1_done edge%0d: got %b want %b", k, done2, want);
      end
      if (done2 === 1'b1) begin
        n_cmp++;
        if (q2.size() == 0) begin
          n_err++;
          $display("FAIL scoreboard2: queue empty at done, result=%b", result2);
        end else begin
          exp_w = q2.pop_front();
          if (result2 !== exp_w) begin
            n_err++;
            $display("FAIL hold1_result edge%0d: got %b want %b", k, result2, exp_w);
          end
        end
      end
    end
    n_cmp++;
    if (done_seen2 - d0 != 2 || q2.size() != 0) begin
      n_err++;
      $display("FAIL hold1_count: dones=%0d left=%0d want 2/0", done_seen2 - d0, q2.size());
    end
  endtask

  task automatic test_reset_mid();
    int d0;
    mode1 = 1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk); #1;
    end
    n_cmp++;
    if ({count1, busy1} !== 3'b101) begin
      n_err++;
      $display("FAIL rstmid_pre: count,busy=%b want 101", {count1, busy1});
    end
    d0 = done_seen1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({count1, busy1, done1, result1, valid1} !== 9'b0) begin
      n_err++;
      $display("FAIL rstmid_async: got %b want 0", {count1, busy1, done1, result1, valid1});
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (busy1 !== 1'b0 || done1 !== 1'b0) begin
        n_err++;
        $display("FAIL rstmid_idle cyc%0d: busy=%b done=%b want 0/0", k, busy1, done1);
      end
    end
    n_cmp++;
    if (done_seen1 != d0) begin
      n_err++;
      $display("FAIL rstmid_nodone: dones=%0d want %0d", done_seen1, d0);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    done_seen1 = 0;
    done_seen2 = 0;
    mode1 = 0;
    mode2 = 0;
    rst_n = 1'b0;
    start1 = 1'b0; abort1 = 1'b0;
    start2 = 1'b0; abort2 = 1'b0;
    test_reset();
    test_and();
    test_back_to_back();
    test_abort();
    test_hold1();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
